// File: rtl/max_pool_2x2_stream_pkg.sv
// Shared definitions for the LeNet pooling stages: pixel format,
// default layer dimensions and the signed-max helper.
package max_pool_2x2_stream_pkg;

  // Pixel format: signed Q8.8
  localparam int POOL_DW     = 16;
  localparam int Q_FRAC_BITS = 8;

  // First pooling layer (after conv1): 28x28x6
  localparam int LENET_P1_WIDTH  = 28;
  localparam int LENET_P1_HEIGHT = 28;
  localparam int LENET_P1_DEPTH  = 6;

  // Second pooling layer (after conv2): 10x10x16
  localparam int LENET_P2_WIDTH  = 10;
  localparam int LENET_P2_HEIGHT = 10;
  localparam int LENET_P2_DEPTH  = 16;

  // Signed two's-complement max; on a tie the operands are equal anyway
  function automatic logic [POOL_DW-1:0] smax(input logic [POOL_DW-1:0] a,
                                              input logic [POOL_DW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Single-port register array holding one row of horizontal pair maxima.
// Writes are synchronous; the read port is combinational on the same address.
module pool_line_buffer #(
  parameter int ENTRIES = 14,
  parameter int DW      = 16,
  parameter int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [ENTRIES];

  // Storage write; contents need no reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 stride-2 max pool over channel-major raster pixels.
// Even rows fold each column pair into the line buffer; odd rows combine the
// pair with the stored maximum and emit one pooled pixel per window.
module max_pool_2x2_stream
  import max_pool_2x2_stream_pkg::*;
#(
  parameter int WIDTH  = LENET_P1_WIDTH,
  parameter int HEIGHT = LENET_P1_HEIGHT,
  parameter int DEPTH  = LENET_P1_DEPTH,
  parameter int DW     = POOL_DW          // smax is defined at POOL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          frame_done
);

  localparam int CW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DCW  = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
  localparam int LB_N = WIDTH / 2;
  localparam int AW   = (LB_N > 1) ? $clog2(LB_N) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [DCW-1:0] CH_LAST  = DCW'(DEPTH - 1);

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [DCW-1:0] ch_q, ch_d;
  logic [DW-1:0]  pair_q, pair_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic           out_last_q, out_last_d;
  logic           frame_done_q, frame_done_d;

  logic           in_fire, out_fire, odd_col, odd_row, win_done, lb_we;
  logic [AW-1:0]  lb_addr;
  logic [DW-1:0]  lb_rdata, pair_max;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign odd_col  = col_q[0];
  assign odd_row  = row_q[0];
  assign pair_max = smax(pair_q, in_data);
  assign lb_we    = in_fire && odd_col && !odd_row;
  assign lb_addr  = AW'(col_q >> 1);
  // in_fire already implies the output register is free or draining,
  // so a completed window never overwrites a stalled result
  assign win_done = in_fire && odd_col && odd_row;

  pool_line_buffer #(
    .ENTRIES (LB_N),
    .DW      (DW),
    .AW      (AW)
  ) u_line_buffer (
    .clk_i   (clk),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (pair_max),
    .rdata_o (lb_rdata)
  );

  // Raster position counters: col, then row, then channel
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (in_fire) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + DCW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Pair capture, window completion and output register next state
  always_comb begin
    pair_d       = pair_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    frame_done_d = out_fire && out_last_q;
    if (in_fire && !odd_col) pair_d = in_data;
    if (out_fire) out_valid_d = 1'b0;
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = smax(pair_max, lb_rdata);
      out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST) && (ch_q == CH_LAST);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      ch_q         <= '0;
      pair_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ch_q         <= ch_d;
      pair_q       <= pair_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Bench for max_pool_2x2_stream: three instances (4x4x1, 4x4x2, 28x28x6)
// share clock and reset; one instance at a time is driven and monitored.
module tb_max_pool_2x2_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready = '1;
  logic [2:0]  out_last;
  logic [2:0]  frame_done;
  logic [15:0] in_data  [3];
  logic [15:0] out_data [3];

  always #5 clk = ~clk;

  max_pool_2x2_stream #(.WIDTH(4), .HEIGHT(4), .DEPTH(1), .DW(16)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .frame_done(frame_done[0]));

  max_pool_2x2_stream #(.WIDTH(4), .HEIGHT(4), .DEPTH(2), .DW(16)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .frame_done(frame_done[1]));

  max_pool_2x2_stream #(.WIDTH(28), .HEIGHT(28), .DEPTH(6), .DW(16)) u_big (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_last(out_last[2]), .frame_done(frame_done[2]));

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tb_smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  int          sel       = 0;
  bit          mon_en    = 1'b0;
  bit          rnd_ready = 1'b0;
  logic [15:0] got_data [$];
  bit          got_last [$];
  int          fd_cnt    = 0;
  bit          fd_exp    = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] held_data;
  logic        held_last;

  // Output monitor on the falling edge
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      fd_exp     = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check_eq("in_ready_rule", {31'b0, in_ready[sel]}, {31'b0, !(out_valid[sel] && !out_ready[sel])});
      check_eq("frame_done", {31'b0, frame_done[sel]}, {31'b0, fd_exp});
      if (frame_done[sel]) fd_cnt++;
      if (stall_prev) begin
        check_eq("stall_data", {16'b0, out_data[sel]}, {16'b0, held_data});
        check_eq("stall_last", {31'b0, out_last[sel]}, {31'b0, held_last});
      end
      if (out_valid[sel] && out_ready[sel]) begin
        got_data.push_back(out_data[sel]);
        got_last.push_back(out_last[sel]);
        fd_exp = out_last[sel];
      end else begin
        fd_exp = 1'b0;
      end
      stall_prev = out_valid[sel] && !out_ready[sel];
      held_data  = out_data[sel];
      held_last  = out_last[sel];
    end
  end

  // Downstream ready: all high, or 30% duty on the selected instance
  always @(posedge clk) begin
    #1;
    out_ready = '1;
    if (rnd_ready) out_ready[sel] = ($urandom_range(0, 99) < 30);
  end

  logic [15:0] stim_q [$];
  logic [15:0] exp_data [$];
  bit          exp_last [$];
  int          stall_cnt;
  int          rd_base = 0;

  task automatic drive_stream();
    bit ok;
    int waits;
    stall_cnt = 0;
    foreach (stim_q[i]) begin
      in_valid[sel] = 1'b1;
      in_data[sel]  = stim_q[i];
      waits = 0;
      do begin
        @(negedge clk);
        ok = in_ready[sel];
        @(posedge clk);
        #1;
        if (!ok) begin
          stall_cnt++;
          waits++;
        end
      end while (!ok && waits < 1000);
      if (!ok) begin
        check_eq("accept_timeout", {31'b0, ok}, 32'd1);
        break;
      end
    end
    in_valid[sel] = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int cyc = 0;
    while ((got_data.size() - rd_base) < n && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_outputs(input string tag);
    int n;
    n = got_data.size() - rd_base;
    check_eq({tag, "_count"}, n, exp_data.size());
    for (int i = 0; i < n && i < exp_data.size(); i++) begin
      check_eq($sformatf("%s_data[%0d]", tag, i), {16'b0, got_data[rd_base+i]}, {16'b0, exp_data[i]});
      check_eq($sformatf("%s_last[%0d]", tag, i), {31'b0, got_last[rd_base+i]}, {31'b0, exp_last[i]});
    end
    rd_base = got_data.size();
    exp_data.delete();
    exp_last.delete();
  endtask

  task automatic push_exp(input logic [15:0] d, input bit l);
    exp_data.push_back(d);
    exp_last.push_back(l);
  endtask

  // Software reference over stim_q for a W x H x D frame
  task automatic build_ref(input int w, input int h, input int d);
    int b;
    logic [15:0] m;
    for (int ch = 0; ch < d; ch++)
      for (int r = 0; r < h; r += 2)
        for (int c = 0; c < w; c += 2) begin
          b = ch*w*h + r*w + c;
          m = tb_smax(tb_smax(stim_q[b], stim_q[b+1]), tb_smax(stim_q[b+w], stim_q[b+w+1]));
          push_exp(m, (ch == d-1) && (r == h-2) && (c == w-2));
        end
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    in_valid = '0;
    for (int k = 0; k < 3; k++) in_data[k] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_out_valid",  {31'b0, out_valid[k]},  32'd0);
      check_eq("rst_out_last",   {31'b0, out_last[k]},   32'd0);
      check_eq("rst_frame_done", {31'b0, frame_done[k]}, 32'd0);
      check_eq("rst_out_data",   {16'b0, out_data[k]},   32'd0);
      check_eq("rst_in_ready",   {31'b0, in_ready[k]},   32'd1);
    end
    rst    = 1'b0;
    mon_en = 1'b1;

    // 4x4x1 raster ramp
    sel = 0; fd_cnt = 0;
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i));
    drive_stream();
    wait_outputs(4);
    push_exp(16'd5, 0); push_exp(16'd7, 0); push_exp(16'd13, 0); push_exp(16'd15, 1);
    compare_outputs("ramp");
    check_eq("ramp_frame_done_cnt", fd_cnt, 1);

    // Signed compare: -1/256 beats -1.0, -2.0 and -128.0
    fd_cnt = 0;
    stim_q.delete();
    for (int i = 0; i < 16; i++) stim_q.push_back(16'h8000);
    stim_q[0] = 16'hFF00; stim_q[1] = 16'h8000; stim_q[4] = 16'hFE00; stim_q[5] = 16'hFFFF;
    drive_stream();
    wait_outputs(4);
    push_exp(16'hFFFF, 0); push_exp(16'h8000, 0); push_exp(16'h8000, 0); push_exp(16'h8000, 1);
    compare_outputs("signed");
    check_eq("signed_frame_done_cnt", fd_cnt, 1);

    // Two back-to-back frames; first seeds the line buffer with large values
    fd_cnt = 0;
    stim_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        stim_q.push_back((r % 2 == 0) ? 16'(16'h7F00 + c) : 16'h0001);
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i));
    drive_stream();
    wait_outputs(8);
    push_exp(16'h7F01, 0); push_exp(16'h7F03, 0); push_exp(16'h7F01, 0); push_exp(16'h7F03, 1);
    push_exp(16'd5, 0);    push_exp(16'd7, 0);    push_exp(16'd13, 0);   push_exp(16'd15, 1);
    compare_outputs("b2b");
    check_eq("b2b_frame_done_cnt", fd_cnt, 2);

    // 4x4x2: 37 pixels, then reset mid-frame, then a fresh frame
    sel = 1; fd_cnt = 0;
    stim_q.delete();
    for (int i = 0; i < 37; i++) stim_q.push_back(16'(100 + i));
    drive_stream();
    wait_outputs(8);
    push_exp(16'd105, 0); push_exp(16'd107, 0); push_exp(16'd113, 0); push_exp(16'd115, 0);
    push_exp(16'd121, 0); push_exp(16'd123, 0); push_exp(16'd129, 0); push_exp(16'd131, 1);
    compare_outputs("pre_rst");
    check_eq("pre_rst_frame_done_cnt", fd_cnt, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("post_rst_out_valid", {31'b0, out_valid[1]}, 32'd0);
    fd_cnt = 0;
    stim_q.delete();
    for (int i = 0; i < 32; i++) stim_q.push_back(16'(i));
    drive_stream();
    wait_outputs(8);
    push_exp(16'd5, 0);  push_exp(16'd7, 0);  push_exp(16'd13, 0); push_exp(16'd15, 0);
    push_exp(16'd21, 0); push_exp(16'd23, 0); push_exp(16'd29, 0); push_exp(16'd31, 1);
    compare_outputs("post_rst");
    check_eq("post_rst_frame_done_cnt", fd_cnt, 1);

    // Default 28x28x6 random frame at full rate
    sel = 2; fd_cnt = 0;
    stim_q.delete();
    for (int i = 0; i < 28*28*6; i++) stim_q.push_back(16'($urandom));
    build_ref(28, 28, 6);
    drive_stream();
    check_eq("full_rate_in_stalls", stall_cnt, 0);
    wait_outputs(1176);
    compare_outputs("big_full");
    check_eq("big_full_frame_done_cnt", fd_cnt, 1);

    // Same geometry with 30%-duty downstream ready
    fd_cnt = 0;
    rnd_ready = 1'b1;
    stim_q.delete();
    for (int i = 0; i < 28*28*6; i++) stim_q.push_back(16'($urandom));
    build_ref(28, 28, 6);
    drive_stream();
    wait_outputs(1176);
    rnd_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compare_outputs("big_stall");
    check_eq("big_stall_frame_done_cnt", fd_cnt, 1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
